// File: rtl/mem_arb.sv
// mem_arb: two-port (fetch / data) arbiter onto a single fixed-latency memory.
// Optional round-robin arbitration is enabled by defining MEM_ARB_RR_EN;
// without it the data port always wins simultaneous requests.
module mem_arb #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rdy,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rdy,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                own_q, own_d;
    logic                pick_dm;

`ifdef MEM_ARB_RR_EN
    logic                last_q, last_d;

    // On a tie, hand the grant to whichever port lost the previous acceptance
    always_comb pick_dm = dm_req && (!if_req || !last_q);

    // Remember the winner of every accepted transaction (1 = data port)
    always_comb last_d = (state_q == IDLE && (if_req || dm_req)) ? pick_dm : last_q;

    // Last-winner register; reset makes fetch the last winner so dm wins first tie
    always_ff @(posedge clk or posedge rst)
        if (rst) last_q <= 1'b0;
        else     last_q <= last_d;
`else
    // Fixed priority: the data port always wins a tie
    always_comb pick_dm = dm_req;
`endif

    // Next-state logic: accept in IDLE, count latency in ACCESS, report in DONE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        own_d   = own_q;
        case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    state_d = ACCESS;
                    cnt_d   = 4'd0;
                    own_d   = pick_dm;
                    addr_d  = pick_dm ? dm_addr : if_addr;
                    we_d    = pick_dm && dm_we;
                    wdata_d = pick_dm ? dm_wdata : '0;
                end
            end
            ACCESS: begin
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    rdata_d = we_q ? rdata_q : mem_rdata;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and transaction registers, cleared asynchronously so an access aborts at once
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            own_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            own_q   <= own_d;
        end

    // Outputs decode purely from registered state, so reset drops them without a clock
    always_comb begin
        busy      = state_q != IDLE;
        mem_en    = state_q == ACCESS;
        mem_we    = mem_en && we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if_gnt    = mem_en && cnt_q == 4'd0 && !own_q;
        dm_gnt    = mem_en && cnt_q == 4'd0 && own_q;
        if_rdy    = state_q == DONE && !own_q;
        dm_rdy    = state_q == DONE && own_q;
        if_rdata  = rdata_q;
        dm_rdata  = rdata_q;
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameters: ADDR_W, 16, address width; DATA_W, 32, data width; MEM_LAT, 2, memory access cycles (legal range 1..15).
REQ-002 SHALL have ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset, asynchronous, active-high.
- if_req  input  1  instruction-fetch request, read-only.
- if_addr  input  ADDR_W  fetch address.
- if_gnt  output  1  fetch transaction accepted, one-cycle pulse.
- if_rdy  output  1  fetch data valid, one-cycle pulse.
- if_rdata  output  DATA_W  fetch read data.
- dm_req  input  1  data-memory request.
- dm_we  input  1  data request is a write (STR) when 1, read (LOD) when 0.
- dm_addr  input  ADDR_W  data address.
- dm_wdata  input  DATA_W  store data.
- dm_gnt  output  1  data transaction accepted, one-cycle pulse.
- dm_rdy  output  1  data transaction complete, one-cycle pulse.
- dm_rdata  output  DATA_W  load data.
- mem_en  output  1  memory enable.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, valid in the last ACCESS cycle.
- busy  output  1  high in any state other than IDLE.

Function
REQ-003 SHALL implement FSM states IDLE, ACCESS, DONE; transitions IDLE->ACCESS on any req sampled high, ACCESS->DONE when the access counter reaches MEM_LAT-1, DONE->IDLE unconditionally.
REQ-004 SHALL sample if_req/dm_req only in IDLE; a req dropped after acceptance SHALL NOT abort the transaction.
REQ-005 On acceptance SHALL register the winner's address, we (0 for fetch), and wdata; mem_addr/mem_we/mem_wdata SHALL come only from these registers.
REQ-006 SHALL pulse the winner's gnt during the first ACCESS cycle only.
REQ-007 SHALL hold mem_en high for exactly MEM_LAT cycles (all of ACCESS) and low otherwise; mem_we SHALL be high for all those cycles on writes only.
REQ-008 On reads, SHALL capture mem_rdata into a shared DATA_W read register on the last ACCESS edge; if_rdata and dm_rdata SHALL both drive that register's value.
REQ-009 On writes, SHALL leave the read register unchanged.
REQ-010 SHALL pulse the owner's rdy in DONE; req seen in cycle N gives gnt in N+1 and rdy in N+1+MEM_LAT.
REQ-011 A req still high in the IDLE cycle after DONE SHALL start a new transaction; minimum per-transaction period is MEM_LAT+2 cycles.
REQ-012 When both reqs are high in IDLE, SHALL grant dm (fixed priority) unless REQ-016 applies.
REQ-013 gnt and rdy SHALL never be high for both ports in the same cycle.
REQ-014 The access counter SHALL be 4 bits, clear on ACCESS entry, and never wrap.

Reset
REQ-015 While rst is high, SHALL immediately force state IDLE, counter 0, read register 0, last-winner = fetch, and all outputs 0; an access in progress SHALL abort with no rdy, and mem_en SHALL drop without waiting for clk.

Configuration
REQ-016 With MEM_ARB_RR_EN defined, SHALL arbitrate round-robin: on simultaneous reqs, grant the port that did not win the most recent transaction, updating last-winner on every acceptance. Without it, dm SHALL always win (REQ-012) and last-winner logic SHALL be absent.

Verification
REQ-017 Benches SHALL use MEM_LAT=2 and cover:
- Fetch 0x0010, memory returns 0xDEADBEEF -> if_gnt in cycle 1, mem_en cycles 1-2, if_rdy with if_rdata=0xDEADBEEF in cycle 3.
- dm write addr 0x0004, wdata 0x12345678 -> mem_we=1, mem_addr=0x0004 in cycles 1-2, dm_rdy in cycle 3, read register unchanged.
- if_req and dm_req held high together -> without macro dm granted on every acceptance; with MEM_ARB_RR_EN grants alternate dm, if, dm, if.
- rst pulsed mid-ACCESS -> mem_en and busy low in the same cycle, no rdy, next req gets gnt one cycle after rst falls and is sampled.
- dm_req dropped the cycle after dm_gnt -> dm_rdy still pulses in cycle 3; back-to-back held if_req -> gnt every 4 cycles.
